anvil_mem_arbiter: RTL and testbench

//   Downstream neighbour of the anvil core: merges the core's instruction port
//   (i_*) and data port (d_*) onto one single-ported memory bus (mem_*).

---
 rtl/anvil_mem_arbiter_if.sv | 46 ++++
 rtl/anvil_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_anvil_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/anvil_mem_arbiter_if.sv
// Signal bundle between the anvil core's fetch/data ports, the arbiter and the
// single-ported memory. The arbiter uses "slave"; the core+memory side uses "master".
interface anvil_mem_arbiter_if;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;

    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_addr;
    logic [31:0] d_rdata;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    logic        bus_err;

    modport slave (
        input  i_valid, i_addr, i_wdata, i_wstrb,
        output i_ready, i_rdata,
        input  d_valid, d_addr, d_wdata, d_wstrb,
        output d_ready, d_rdata,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        output bus_err
    );

    modport master (
        output i_valid, i_addr, i_wdata, i_wstrb,
        input  i_ready, i_rdata,
        output d_valid, d_addr, d_wdata, d_wstrb,
        input  d_ready, d_rdata,
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        input  bus_err
    );
endinterface

// File: rtl/anvil_mem_arbiter.sv
// Merges the anvil core's fetch and data ports onto one memory bus, one request
// at a time, with an optional watchdog that aborts stalled memory accesses.
module anvil_mem_arbiter #(
    parameter int unsigned D_PRIORITY = 1,
    parameter int unsigned TIMEOUT    = 0,
    parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic               clk,
    input  logic               resetn,
    anvil_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_I_REQ = 2'd1,
        S_D_REQ = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam bit          LP_WD_EN   = (TIMEOUT != 0);
    localparam logic [31:0] LP_WD_LAST = LP_WD_EN ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      r_state;
    state_t      w_next;
    logic        r_last_d;
    logic [31:0] r_wdog;

    logic        r_mem_valid;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;

    logic        r_i_ready;
    logic        r_d_ready;
    logic        r_bus_err;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic        w_issue;
    logic        w_grant_d;
    logic        w_done;
    logic        w_abort;
    logic        w_in_req;
    logic [31:0] w_resp_data;
    logic        w_unused;

    assign w_in_req = (r_state == S_I_REQ) || (r_state == S_D_REQ);
    // The fetch port is read-only, so its write fields are never used.
    assign w_unused = ^{bus.i_wdata, bus.i_wstrb};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_issue     = 1'b0;
        w_grant_d   = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_resp_data = ERR_RDATA;
        case (r_state)
            S_IDLE: begin
                if (bus.i_valid || bus.d_valid) begin
                    w_issue = 1'b1;
                    if (bus.i_valid && bus.d_valid) begin
                        // Round-robin hands a tie to whichever port lost last time.
                        w_grant_d = (D_PRIORITY != 0) ? 1'b1 : ~r_last_d;
                    end else begin
                        w_grant_d = bus.d_valid;
                    end
                    w_next = w_grant_d ? S_D_REQ : S_I_REQ;
                end
            end
            S_I_REQ, S_D_REQ: begin
                if (r_mem_valid && bus.mem_ready) begin
                    w_done      = 1'b1;
                    w_resp_data = bus.mem_rdata;
                    w_next      = S_RESP;
                end else if (LP_WD_EN && (r_wdog == LP_WD_LAST)) begin
                    w_abort = 1'b1;
                    w_next  = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_d    <= 1'b0;
            r_wdog      <= 32'd0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_i_rdata   <= 32'd0;
            r_d_rdata   <= 32'd0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_bus_err <= 1'b0;

            if (w_issue) begin
                r_mem_valid <= 1'b1;
                r_last_d    <= w_grant_d;
                r_wdog      <= 32'd0;
                if (w_grant_d) begin
                    r_mem_addr  <= bus.d_addr;
                    r_mem_wdata <= bus.d_wdata;
                    r_mem_wstrb <= bus.d_wstrb;
                end else begin
                    r_mem_addr  <= bus.i_addr;
                    r_mem_wdata <= 32'd0;
                    r_mem_wstrb <= 4'd0;
                end
            end

            // Completion or abort: the ready pulse is registered so it lands in RESP.
            if (w_done || w_abort) begin
                r_mem_valid <= 1'b0;
                r_bus_err   <= w_abort;
                if (r_state == S_D_REQ) begin
                    r_d_rdata <= w_resp_data;
                    r_d_ready <= 1'b1;
                end else begin
                    r_i_rdata <= w_resp_data;
                    r_i_ready <= 1'b1;
                end
            end else if (w_in_req && LP_WD_EN) begin
                r_wdog <= r_wdog + 32'd1;
            end
        end
    end

    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;
    assign bus.i_ready   = r_i_ready;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_ready   = r_d_ready;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.bus_err   = r_bus_err;
endmodule

// File: tb/tb_anvil_mem_arbiter.sv
// Scoreboard bench: instance 0 is data-priority with an 8-cycle watchdog,
// instance 1 is round-robin with no watchdog; each has a small memory model.
module tb_anvil_mem_arbiter;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    logic [1:0]  ival, dval, mnever, spur;
    logic [31:0] iaddr [2];
    logic [31:0] iwdata[2];
    logic [3:0]  iwstrb[2];
    logic [31:0] daddr [2];
    logic [31:0] dwdata[2];
    logic [3:0]  dwstrb[2];
    int          mwait [2];

    logic [1:0]  irdy, drdy, berr, mvalid;
    logic [31:0] irdata[2];
    logic [31:0] drdata[2];
    logic [31:0] maddr [2];
    logic [31:0] mwd_o [2];
    logic [3:0]  mws_o [2];
    int          mvlen_a[2];

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h0050_0093 : (a ^ 32'hA5A5_0000);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        anvil_mem_arbiter_if bus ();
        anvil_mem_arbiter #(
            .D_PRIORITY(g == 0 ? 1 : 0),
            .TIMEOUT   (g == 0 ? 8 : 0),
            .ERR_RDATA (32'hDEAD_BEEF)
        ) dut (
            .clk   (clk),
            .resetn(resetn),
            .bus   (bus)
        );

        logic        m_rdy = 1'b0;
        logic [31:0] m_rd  = 32'd0;
        int          cnt   = 0;
        int          mvlen = 0;
        logic [31:0] l_addr, l_wdata;
        logic [3:0]  l_wstrb;

        assign bus.i_valid   = ival[g];
        assign bus.i_addr    = iaddr[g];
        assign bus.i_wdata   = iwdata[g];
        assign bus.i_wstrb   = iwstrb[g];
        assign bus.d_valid   = dval[g];
        assign bus.d_addr    = daddr[g];
        assign bus.d_wdata   = dwdata[g];
        assign bus.d_wstrb   = dwstrb[g];
        assign bus.mem_ready = m_rdy;
        assign bus.mem_rdata = m_rd;
        assign irdy[g]       = bus.i_ready;
        assign drdy[g]       = bus.d_ready;
        assign berr[g]       = bus.bus_err;
        assign mvalid[g]     = bus.mem_valid;
        assign irdata[g]     = bus.i_rdata;
        assign drdata[g]     = bus.d_rdata;
        assign maddr[g]      = bus.mem_addr;
        assign mwd_o[g]      = bus.mem_wdata;
        assign mws_o[g]      = bus.mem_wstrb;
        assign mvlen_a[g]    = mvlen;

        // Memory: answers after mwait wait states; spur drives mem_ready while idle.
        always @(negedge clk) begin
            if (bus.mem_valid) begin
                if (cnt == 0) begin
                    l_addr  = bus.mem_addr;
                    l_wdata = bus.mem_wdata;
                    l_wstrb = bus.mem_wstrb;
                end else begin
                    checks++;
                    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== {l_addr, l_wdata, l_wstrb}) begin
                        errors++;
                        $display("FAIL mem_stable dut%0d: got %h/%h/%h, want %h/%h/%h", g,
                                 bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, l_addr, l_wdata, l_wstrb);
                    end
                end
                cnt++;
                mvlen = cnt;
                if (!mnever[g] && (cnt - 1 >= mwait[g])) begin
                    m_rdy = 1'b1;
                    m_rd  = memdata(bus.mem_addr);
                end else begin
                    m_rdy = 1'b0;
                    m_rd  = ~memdata(bus.mem_addr);
                end
            end else begin
                cnt   = 0;
                m_rdy = spur[g];
                m_rd  = 32'h0BAD_0BAD;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic expect_rsp(input int sel, input bit is_d, input logic [31:0] rd, input bit err);
        exp_t e;
        e.is_d  = is_d;
        e.rdata = rd;
        e.err   = err;
        if (sel == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
    endtask

    task automatic mon(input int k);
        exp_t        e;
        logic        got_d;
        logic [31:0] got_rd;
        int          qsz;
        qsz = (k == 0) ? exp_q0.size() : exp_q1.size();
        if (berr[k] && !(irdy[k] || drdy[k])) begin
            checks++;
            errors++;
            $display("FAIL bus_err_alone dut%0d: bus_err=1 without ready", k);
        end
        if (irdy[k] || drdy[k]) begin
            checks++;
            if (irdy[k] && drdy[k]) begin
                errors++;
                $display("FAIL both_ready dut%0d: i_ready=1 d_ready=1, want one", k);
            end else if (qsz == 0) begin
                errors++;
                $display("FAIL unexpected_ready dut%0d: i_ready=%b d_ready=%b, want none", k, irdy[k], drdy[k]);
            end else begin
                if (k == 0) e = exp_q0.pop_front();
                else        e = exp_q1.pop_front();
                got_d  = drdy[k];
                got_rd = got_d ? drdata[k] : irdata[k];
                if ({got_d, got_rd, berr[k]} !== {e.is_d, e.rdata, e.err}) begin
                    errors++;
                    $display("FAIL resp dut%0d: got port_d=%b rdata=%h err=%b, want port_d=%b rdata=%h err=%b",
                             k, got_d, got_rd, berr[k], e.is_d, e.rdata, e.err);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            for (int k = 0; k < 2; k++) mon(k);
        end
    end

    task automatic req(input int sel, input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input bit chk, input logic [31:0] exp_wd,
                       input logic [3:0] exp_ws, output int lat);
        logic rdy;
        @(negedge clk);
        if (is_d) begin
            daddr[sel] = addr; dwdata[sel] = wdata; dwstrb[sel] = wstrb; dval[sel] = 1'b1;
        end else begin
            iaddr[sel] = addr; iwdata[sel] = wdata; iwstrb[sel] = wstrb; ival[sel] = 1'b1;
        end
        lat = 0;
        rdy = 1'b0;
        while (!rdy && lat < 50) begin
            @(negedge clk);
            lat++;
            if (chk && lat == 1)
                check("mem_request", {mvalid[sel], maddr[sel], mwd_o[sel], mws_o[sel]},
                      {1'b1, addr, exp_wd, exp_ws});
            rdy = is_d ? drdy[sel] : irdy[sel];
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL req_timeout dut%0d: no ready within %0d cycles", sel, lat);
        end
        if (is_d) dval[sel] = 1'b0;
        else      ival[sel] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat, lat_d, lat_i;
        resetn = 1'b0;
        ival = '0; dval = '0; mnever = '0; spur = '0;
        for (int k = 0; k < 2; k++) begin
            iaddr[k] = '0; iwdata[k] = '0; iwstrb[k] = '0;
            daddr[k] = '0; dwdata[k] = '0; dwstrb[k] = '0;
            mwait[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_ctrl", {irdy[k], drdy[k], berr[k], mvalid[k], maddr[k], mws_o[k]}, '0);
            check("reset_data", {irdata[k], drdata[k], mwd_o[k]}, '0);
        end
        resetn = 1'b1;

        // Fetch: write fields must be suppressed on the memory bus.
        expect_rsp(0, 1'b0, 32'h0050_0093, 1'b0);
        req(0, 1'b0, 32'h100, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 4'h0, lat);
        check("fetch_latency", lat, 2);
        check("fetch_mv_cycles", mvlen_a[0], 1);

        // Store with 3 wait states.
        mwait[0] = 3;
        expect_rsp(0, 1'b1, 32'hA5A5_2000, 1'b0);
        req(0, 1'b1, 32'h2000, 32'hCAFE_F00D, 4'hF, 1'b1, 32'hCAFE_F00D, 4'hF, lat);
        check("store_latency", lat, 5);
        check("store_mv_cycles", mvlen_a[0], 4);
        check("store_i_rdata_held", irdata[0], 32'h0050_0093);

        // Contention, data priority.
        mwait[0] = 0;
        expect_rsp(0, 1'b1, 32'hA5A5_0040, 1'b0);
        expect_rsp(0, 1'b0, 32'hA5A5_0080, 1'b0);
        fork
            req(0, 1'b1, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, lat_d);
            req(0, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, lat_i);
        join
        check("prio_d_latency", lat_d, 2);
        check("prio_i_latency", lat_i, 5);

        // mem_ready with mem_valid low must be ignored.
        spur[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("spur_i_rdata_held", irdata[0], 32'hA5A5_0080);
        mwait[0] = 2;
        expect_rsp(0, 1'b0, 32'h0050_0093, 1'b0);
        req(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'h0, 4'h0, lat);
        check("spur_fetch_latency", lat, 4);
        spur[0] = 1'b0;

        // Watchdog abort.
        mnever[0] = 1'b1;
        expect_rsp(0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        req(0, 1'b1, 32'h3000, 32'h0, 4'h0, 1'b1, 32'h0, 4'h0, lat);
        check("timeout_latency", lat, 9);
        check("timeout_mv_cycles", mvlen_a[0], 8);
        check("timeout_i_rdata_held", irdata[0], 32'h0050_0093);
        mnever[0] = 1'b0;

        // Reset in the middle of a data request.
        mwait[0] = 20;
        @(negedge clk);
        daddr[0] = 32'h4000; dwstrb[0] = 4'h0; dval[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pre_mem_valid", mvalid[0], 1'b1);
        #2 resetn = 1'b0;
        #1 check("rst_mid_outputs", {mvalid[0], drdy[0], irdy[0], berr[0], drdata[0]}, '0);
        dval[0] = 1'b0;
        mwait[0] = 0;
        @(negedge clk);
        resetn = 1'b1;

        // Round-robin: history is I after reset, so D wins the first tie.
        expect_rsp(1, 1'b1, 32'hA5A5_0050, 1'b0);
        expect_rsp(1, 1'b0, 32'hA5A5_0060, 1'b0);
        fork
            req(1, 1'b1, 32'h50, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, lat_d);
            req(1, 1'b0, 32'h60, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, lat_i);
        join
        check("rr1_d_latency", lat_d, 2);
        check("rr1_i_latency", lat_i, 5);

        expect_rsp(1, 1'b1, 32'hA5A5_0070, 1'b0);
        req(1, 1'b1, 32'h70, 32'h0, 4'h0, 1'b1, 32'h0, 4'h0, lat);
        check("rr_d_alone_latency", lat, 2);

        // Last grant was D, so I wins this tie.
        expect_rsp(1, 1'b0, 32'hA5A5_0090, 1'b0);
        expect_rsp(1, 1'b1, 32'hA5A5_00A0, 1'b0);
        fork
            req(1, 1'b0, 32'h90, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, lat_i);
            req(1, 1'b1, 32'hA0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, lat_d);
        join
        check("rr2_i_latency", lat_i, 2);
        check("rr2_d_latency", lat_d, 5);

        repeat (4) @(negedge clk);
        check("sb_drain", exp_q0.size() + exp_q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
